pred_reg_file_mw: RTL and testbench



---
 rtl/pred_rf_pkg.sv | 16 +
 rtl/pred_rf_read_port.sv | 40 ++++
 rtl/pred_reg_file_mw.sv | 143 ++++++++++++++
 tb/tb_pred_reg_file_mw.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pred_rf_pkg.sv
// Shared definitions for the multi-warp predicate register file:
// clear-engine state encoding and default geometry.
package pred_rf_pkg;

    localparam int DEF_NUM_LANES    = 8;
    localparam int DEF_NUM_REGS     = 64;
    localparam int DEF_NUM_WARPS    = 16;
    localparam int DEF_NUM_RD_PORTS = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

endpackage

// File: rtl/pred_rf_read_port.sv
// One registered predicate read port; a same-cycle write to the addressed
// register is forwarded lane-by-lane so the read sees the post-write value.
module pred_rf_read_port
    import pred_rf_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int RW        = 6,
    parameter int WW        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_LANES-1:0] rd_en,
    input  logic [WW-1:0]        rd_warp,
    input  logic [RW-1:0]        rd_addr,
    input  logic [NUM_LANES-1:0] mem_word,
    input  logic [NUM_LANES-1:0] wr_en,
    input  logic [WW-1:0]        wr_warp,
    input  logic [RW-1:0]        wr_addr,
    input  logic [NUM_LANES-1:0] wr_data,
    output logic [NUM_LANES-1:0] rd_data,
    output logic                 rd_valid
);

    logic                 hit;
    logic [NUM_LANES-1:0] word;

    assign hit  = (rd_warp == wr_warp) && (rd_addr == wr_addr);
    assign word = hit ? ((mem_word & ~wr_en) | (wr_data & wr_en)) : mem_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_data  <= rd_en & word;
            rd_valid <= |rd_en;
        end
    end

endmodule

// File: rtl/pred_reg_file_mw.sv
// Multi-warp predicate register file: per-lane storage, external/sweep write
// arbitration and the per-warp bulk-clear engine; reads via pred_rf_read_port.
module pred_reg_file_mw
    import pred_rf_pkg::*;
#(
    parameter int NUM_LANES    = DEF_NUM_LANES,
    parameter int NUM_REGS     = DEF_NUM_REGS,
    parameter int NUM_WARPS    = DEF_NUM_WARPS,
    parameter int NUM_RD_PORTS = DEF_NUM_RD_PORTS,
    parameter int RW           = $clog2(NUM_REGS),
    parameter int WW           = $clog2(NUM_WARPS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_RD_PORTS*NUM_LANES-1:0] rd_en,
    input  logic [NUM_RD_PORTS*WW-1:0]        rd_warp,
    input  logic [NUM_RD_PORTS*RW-1:0]        rd_addr,
    output logic [NUM_RD_PORTS*NUM_LANES-1:0] rd_data,
    output logic [NUM_RD_PORTS-1:0]           rd_valid,
    input  logic [NUM_LANES-1:0]              wr_en,
    input  logic [WW-1:0]                     wr_warp,
    input  logic [RW-1:0]                     wr_addr,
    input  logic [NUM_LANES-1:0]              wr_data,
    output logic                              wr_ready,
    input  logic                              clr_req,
    input  logic [WW-1:0]                     clr_warp,
    input  logic                              clr_value,
    output logic                              clr_busy,
    output logic                              clr_done
);

    // A single-warp build has no warp index bits; use a 1-bit dummy internally.
    localparam int WWI = (WW > 0) ? WW : 1;

    logic [NUM_LANES-1:0] mem [NUM_WARPS][NUM_REGS];

    clr_state_t     state;
    logic [RW-1:0]  ptr;
    logic [WWI-1:0] clr_warp_q;
    logic           clr_value_q;

    logic [WWI-1:0]       wr_warp_i;
    logic [WWI-1:0]       clr_warp_i;
    logic [NUM_LANES-1:0] we;
    logic [NUM_LANES-1:0] wd;
    logic [WWI-1:0]       ww;
    logic [RW-1:0]        wa;

    if (WW > 0) begin : g_warp
        assign wr_warp_i  = wr_warp;
        assign clr_warp_i = clr_warp;
    end else begin : g_nowarp
        assign wr_warp_i  = '0;
        assign clr_warp_i = '0;
    end

    assign clr_busy = (state != IDLE);
    assign wr_ready = !clr_busy && !clr_req;

    // The sweep owns the write port; external writes pass only when ready.
    always_comb begin
        we = '0;
        wd = wr_data;
        ww = wr_warp_i;
        wa = wr_addr;
        if (state == SWEEP) begin
            we = '1;
            wd = {NUM_LANES{clr_value_q}};
            ww = clr_warp_q;
            wa = ptr;
        end else if (wr_ready) begin
            we = wr_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '{default: '0};
        end else if (int'(wa) < NUM_REGS && int'(ww) < NUM_WARPS) begin
            mem[ww][wa] <= (mem[ww][wa] & ~we) | (wd & we);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            clr_warp_q  <= '0;
            clr_value_q <= 1'b0;
            clr_done    <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                IDLE: if (clr_req) begin
                    state       <= SWEEP;
                    ptr         <= '0;
                    clr_warp_q  <= clr_warp_i;
                    clr_value_q <= clr_value;
                end
                SWEEP: if (ptr == RW'(NUM_REGS - 1)) begin
                    state    <= DONE;
                    clr_done <= 1'b1;
                end else begin
                    ptr <= ptr + RW'(1);
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        logic [WWI-1:0] rw_i;
        logic [RW-1:0]  ra_i;

        if (WW > 0) begin : g_w
            assign rw_i = rd_warp[p*WW +: WW];
        end else begin : g_nw
            assign rw_i = '0;
        end
        assign ra_i = rd_addr[p*RW +: RW];

        pred_rf_read_port #(
            .NUM_LANES (NUM_LANES),
            .RW        (RW),
            .WW        (WWI)
        ) u_port (
            .clk      (clk),
            .rst      (rst),
            .rd_en    (rd_en[p*NUM_LANES +: NUM_LANES]),
            .rd_warp  (rw_i),
            .rd_addr  (ra_i),
            .mem_word (mem[rw_i][ra_i]),
            .wr_en    (we),
            .wr_warp  (ww),
            .wr_addr  (wa),
            .wr_data  (wd),
            .rd_data  (rd_data[p*NUM_LANES +: NUM_LANES]),
            .rd_valid (rd_valid[p])
        );
    end

endmodule

// File: tb/tb_pred_reg_file_mw.sv
// Self-checking bench for pred_reg_file_mw against an array-based storage model.
module tb_pred_reg_file_mw;

    localparam int L  = 8;
    localparam int R  = 64;
    localparam int W  = 16;
    localparam int P  = 2;
    localparam int RW = 6;
    localparam int WW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [P*L-1:0]  rd_en;
    logic [P*WW-1:0] rd_warp;
    logic [P*RW-1:0] rd_addr;
    logic [P*L-1:0]  rd_data;
    logic [P-1:0]    rd_valid;
    logic [L-1:0]    wr_en;
    logic [WW-1:0]   wr_warp;
    logic [RW-1:0]   wr_addr;
    logic [L-1:0]    wr_data;
    logic            wr_ready;
    logic            clr_req;
    logic [WW-1:0]   clr_warp;
    logic            clr_value;
    logic            clr_busy;
    logic            clr_done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [L-1:0] mem_m [W][R];
    logic [L-1:0] exp_data [P];
    logic         exp_valid [P];

    always #5 clk = ~clk;

    pred_reg_file_mw #(
        .NUM_LANES    (L),
        .NUM_REGS     (R),
        .NUM_WARPS    (W),
        .NUM_RD_PORTS (P)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en),
        .rd_warp   (rd_warp),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .wr_en     (wr_en),
        .wr_warp   (wr_warp),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .clr_req   (clr_req),
        .clr_warp  (clr_warp),
        .clr_value (clr_value),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done)
    );

    task automatic idle_inputs();
        rd_en = '0; rd_warp = '0; rd_addr = '0;
        wr_en = '0; wr_warp = '0; wr_addr = '0; wr_data = '0;
        clr_req = 1'b0; clr_warp = '0; clr_value = 1'b0;
    endtask

    task automatic set_rd(input int p, input logic [L-1:0] en, input int w, input int a);
        rd_en[p*L +: L]     = en;
        rd_warp[p*WW +: WW] = WW'(w);
        rd_addr[p*RW +: RW] = RW'(a);
    endtask

    task automatic set_wr(input logic [L-1:0] en, input int w, input int a, input logic [L-1:0] d);
        wr_en = en; wr_warp = WW'(w); wr_addr = RW'(a); wr_data = d;
    endtask

    task automatic zero_model();
        for (int w = 0; w < W; w++)
            for (int a = 0; a < R; a++)
                mem_m[w][a] = '0;
    endtask

    // One clock: apply this cycle's accepted writes to the model, then a read
    // of the same cycle observes the updated register (write-to-read bypass).
    task automatic step(input bit ext_ok, input bit sw, input int sw_w, input int sw_a, input bit sw_v);
        if (ext_ok)
            for (int l = 0; l < L; l++)
                if (wr_en[l]) mem_m[wr_warp][wr_addr][l] = wr_data[l];
        if (sw) mem_m[sw_w][sw_a] = {L{sw_v}};
        for (int p = 0; p < P; p++) begin
            exp_data[p]  = rd_en[p*L +: L] & mem_m[rd_warp[p*WW +: WW]][rd_addr[p*RW +: RW]];
            exp_valid[p] = |rd_en[p*L +: L];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        zero_model();
        n_cmp++; if (rd_data !== '0)   begin n_bad++; $display("FAIL reset_rd_data got %h expected 0", rd_data); end
        n_cmp++; if (rd_valid !== '0)  begin n_bad++; $display("FAIL reset_rd_valid got %b expected 0", rd_valid); end
        n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_wr_ready got %b expected 1", wr_ready); end
        n_cmp++; if (clr_busy !== 1'b0) begin n_bad++; $display("FAIL reset_clr_busy got %b expected 0", clr_busy); end
        n_cmp++; if (clr_done !== 1'b0) begin n_bad++; $display("FAIL reset_clr_done got %b expected 0", clr_done); end
        rst = 1'b0;
    endtask

    task automatic test_fill_readback();
        for (int w = 0; w < W; w++)
            for (int a = 0; a < R; a++) begin
                idle_inputs();
                set_wr(8'hFF, w, a, 8'hA5 ^ L'(a));
                step(1, 0, 0, 0, 0);
            end
        for (int w = 0; w < W; w++)
            for (int a = 0; a < R; a++) begin
                idle_inputs();
                set_rd(0, 8'hFF, w, a);
                if (a % 2 == 0) set_rd(1, 8'hFF, w, a);
                else            set_rd(1, 8'hFF, $urandom_range(W-1), $urandom_range(R-1));
                step(1, 0, 0, 0, 0);
                for (int p = 0; p < P; p++) begin
                    n_cmp++;
                    if (rd_data[p*L +: L] !== exp_data[p]) begin
                        n_bad++;
                        $display("FAIL fill_read p%0d w%0d a%0d got %h expected %h", p, w, a, rd_data[p*L +: L], exp_data[p]);
                    end
                end
                n_cmp++;
                if (rd_valid !== 2'b11) begin n_bad++; $display("FAIL fill_valid got %b expected 11", rd_valid); end
            end
    endtask

    task automatic test_partial_lanes();
        idle_inputs(); set_wr(8'hFF, 1, 9, 8'hFF); step(1, 0, 0, 0, 0);
        idle_inputs(); set_wr(8'h0F, 1, 9, 8'h00); step(1, 0, 0, 0, 0);
        idle_inputs();
        set_rd(0, 8'hFF, 1, 9);
        set_rd(1, 8'h0F, 1, 9);
        step(1, 0, 0, 0, 0);
        n_cmp++; if (rd_data[7:0] !== 8'hF0)  begin n_bad++; $display("FAIL partial_write got %h expected f0", rd_data[7:0]); end
        n_cmp++; if (rd_data[15:8] !== 8'h00) begin n_bad++; $display("FAIL partial_rden got %h expected 00", rd_data[15:8]); end
        idle_inputs();
        set_rd(0, 8'h00, 1, 9);
        set_rd(1, 8'hF0, 1, 9);
        step(1, 0, 0, 0, 0);
        n_cmp++; if (rd_valid !== 2'b10)      begin n_bad++; $display("FAIL partial_valid got %b expected 10", rd_valid); end
        n_cmp++; if (rd_data !== 16'hF000)    begin n_bad++; $display("FAIL partial_mask got %h expected f000", rd_data); end
    endtask

    task automatic test_bypass();
        idle_inputs(); set_wr(8'hFF, 3, 5, 8'h00); step(1, 0, 0, 0, 0);
        idle_inputs();
        set_wr(8'h3C, 3, 5, 8'hFF);
        set_rd(1, 8'hFF, 3, 5);
        set_rd(0, 8'hF0, 3, 5);
        step(1, 0, 0, 0, 0);
        n_cmp++; if (rd_data[15:8] !== 8'h3C) begin n_bad++; $display("FAIL bypass_p1 got %h expected 3c", rd_data[15:8]); end
        n_cmp++; if (rd_data[7:0] !== 8'h30)  begin n_bad++; $display("FAIL bypass_p0 got %h expected 30", rd_data[7:0]); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            idle_inputs();
            set_wr(L'($urandom), $urandom_range(W-1), $urandom_range(R-1), L'($urandom));
            for (int p = 0; p < P; p++) begin
                if ($urandom_range(2) == 0)
                    set_rd(p, L'($urandom), int'(wr_warp), int'(wr_addr));
                else
                    set_rd(p, L'($urandom), $urandom_range(W-1), $urandom_range(R-1));
            end
            step(1, 0, 0, 0, 0);
            for (int p = 0; p < P; p++) begin
                n_cmp++;
                if (rd_data[p*L +: L] !== exp_data[p] || rd_valid[p] !== exp_valid[p]) begin
                    n_bad++;
                    $display("FAIL random_rd p%0d it%0d got %h/%b expected %h/%b", p, i,
                             rd_data[p*L +: L], rd_valid[p], exp_data[p], exp_valid[p]);
                end
            end
        end
    endtask

    task automatic test_clear();
        int low_cnt;
        int done_cnt;
        int done_at;
        for (int a = 0; a < R; a++) begin
            idle_inputs(); set_wr(8'hFF, 2, a, 8'hFF); step(1, 0, 0, 0, 0);
            idle_inputs(); set_wr(8'hFF, 7, a, 8'hFF); step(1, 0, 0, 0, 0);
        end
        // clr_req together with a write: the write must be dropped.
        idle_inputs();
        clr_req = 1'b1; clr_warp = 4'd7; clr_value = 1'b0;
        set_wr(8'hFF, 2, 0, 8'h00);
        #1;
        n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL clr_req_wr_ready got %b expected 0", wr_ready); end
        step(0, 0, 0, 0, 0);
        low_cnt = 0; done_cnt = 0; done_at = 0;
        for (int i = 1; i <= 200; i++) begin
            if (wr_ready === 1'b1) break;
            low_cnt++;
            if (clr_done === 1'b1) begin done_cnt++; done_at = i; end
            idle_inputs();
            if (i == 21) begin clr_req = 1'b1; clr_warp = 4'd2; clr_value = 1'b0; end
            if (i <= R) begin
                set_rd(0, 8'hFF, 7, i - 1);
                set_rd(1, 8'hFF, 7, R - 1);
                step(0, 1, 7, i - 1, 1'b0);
                for (int p = 0; p < P; p++) begin
                    n_cmp++;
                    if (rd_data[p*L +: L] !== exp_data[p]) begin
                        n_bad++;
                        $display("FAIL sweep_read p%0d cyc%0d got %h expected %h", p, i, rd_data[p*L +: L], exp_data[p]);
                    end
                end
            end else begin
                step(0, 0, 0, 0, 0);
            end
        end
        n_cmp++; if (low_cnt != 65) begin n_bad++; $display("FAIL clr_ready_low got %0d expected 65", low_cnt); end
        n_cmp++; if (done_at != 65) begin n_bad++; $display("FAIL clr_done_cycle got %0d expected 65", done_at); end
        for (int i = 0; i < 80; i++) begin
            idle_inputs();
            if (clr_done === 1'b1) done_cnt++;
            step(1, 0, 0, 0, 0);
        end
        n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL clr_done_count got %0d expected 1", done_cnt); end
        n_cmp++; if (clr_busy !== 1'b0) begin n_bad++; $display("FAIL clr_busy_after got %b expected 0", clr_busy); end
        for (int a = 0; a < R; a++) begin
            idle_inputs();
            set_rd(0, 8'hFF, 7, a);
            set_rd(1, 8'hFF, 2, a);
            step(1, 0, 0, 0, 0);
            n_cmp++; if (rd_data[7:0] !== 8'h00)  begin n_bad++; $display("FAIL clr_warp7 a%0d got %h expected 00", a, rd_data[7:0]); end
            n_cmp++; if (rd_data[15:8] !== 8'hFF) begin n_bad++; $display("FAIL keep_warp2 a%0d got %h expected ff", a, rd_data[15:8]); end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int done_cnt;
        idle_inputs();
        set_wr(8'hFF, 5, 40, 8'h5A); step(1, 0, 0, 0, 0);
        idle_inputs();
        clr_req = 1'b1; clr_warp = 4'd5; clr_value = 1'b1;
        step(0, 0, 0, 0, 0);
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            idle_inputs();
            step(0, 1, 5, k, 1'b1);
            if (clr_done === 1'b1) done_cnt++;
        end
        idle_inputs();
        rst = 1'b1;
        step(0, 0, 0, 0, 0);
        rst = 1'b0;
        zero_model();
        n_cmp++; if (clr_busy !== 1'b0) begin n_bad++; $display("FAIL rst_sweep_busy got %b expected 0", clr_busy); end
        n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL rst_sweep_ready got %b expected 1", wr_ready); end
        for (int i = 0; i < 80; i++) begin
            idle_inputs();
            set_rd(0, 8'hFF, 5, $urandom_range(R-1));
            set_rd(1, 8'hFF, $urandom_range(W-1), $urandom_range(R-1));
            if (clr_done === 1'b1) done_cnt++;
            step(1, 0, 0, 0, 0);
            for (int p = 0; p < P; p++) begin
                n_cmp++;
                if (rd_data[p*L +: L] !== exp_data[p]) begin
                    n_bad++;
                    $display("FAIL rst_zeroed p%0d got %h expected %h", p, rd_data[p*L +: L], exp_data[p]);
                end
            end
        end
        n_cmp++; if (done_cnt != 0) begin n_bad++; $display("FAIL rst_sweep_done got %0d expected 0", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_fill_readback();
        test_partial_lanes();
        test_bypass();
        test_random();
        test_clear();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
